// File: rtl/tpu_pkg.sv
// Shared constants and enums for the systolic-array command sequencer.
package tpu_pkg;

    localparam int BITS_AB    = 8;
    localparam int DIM        = 8;
    localparam int ROWBITS    = $clog2(DIM);
    localparam int RUN_CYCLES = 3*DIM - 2;
    localparam int CNTBITS    = $clog2(3*DIM - 1);
    localparam int BCNTBITS   = $clog2(DIM + 1);

    typedef enum logic [1:0] {
        OP_LOAD_A = 2'd0,
        OP_LOAD_B = 2'd1,
        OP_RUN    = 2'd2,
        OP_CLEAR  = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/tpu_seq.sv
// Command sequencer feeding memA/memB and timing the en burst into the array.
// Optional busy-cycle counter on perf_cycles when SEQ_PERF_CNT_EN is defined.
module tpu_seq
    import tpu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [ROWBITS-1:0]       cmd_row,
    input  logic [DIM*BITS_AB-1:0]   cmd_data,
    output logic                     a_wren,
    output logic [ROWBITS-1:0]       a_row,
    output logic [DIM*BITS_AB-1:0]   a_in,
    output logic                     b_wren,
    output logic [DIM*BITS_AB-1:0]   b_in,
    output logic                     en,
    output logic                     busy,
    output logic                     done,
    output logic                     err
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]              perf_cycles
`endif
);

    state_e                   state_q, state_d;
    logic [CNTBITS-1:0]       cnt_q, cnt_d;
    logic [DIM-1:0]           a_loaded_q, a_loaded_d;
    logic [BCNTBITS-1:0]      b_count_q, b_count_d;
    logic                     a_wren_q, a_wren_d;
    logic [ROWBITS-1:0]       a_row_q, a_row_d;
    logic [DIM*BITS_AB-1:0]   a_in_q, a_in_d;
    logic                     b_wren_q, b_wren_d;
    logic [DIM*BITS_AB-1:0]   b_in_q, b_in_d;
    logic                     en_q, en_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     accept_s;
    logic                     operands_ready_s;

    // Ready drops for the whole reset cycle, not just until the state settles.
    assign cmd_ready        = (state_q == S_IDLE) && !rst;
    assign accept_s         = cmd_valid && cmd_ready;
    assign operands_ready_s = (&a_loaded_q) && (b_count_q == BCNTBITS'(DIM));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_loaded_d = a_loaded_q;
        b_count_d  = b_count_q;
        a_wren_d   = 1'b0;
        a_row_d    = a_row_q;
        a_in_d     = a_in_q;
        b_wren_d   = 1'b0;
        b_in_d     = b_in_q;
        en_d       = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    case (opcode_e'(cmd_op))
                        OP_LOAD_A: begin
                            a_wren_d            = 1'b1;
                            a_row_d             = cmd_row;
                            a_in_d              = cmd_data;
                            a_loaded_d[cmd_row] = 1'b1;
                        end
                        OP_LOAD_B: begin
                            b_wren_d = 1'b1;
                            b_in_d   = cmd_data;
                            if (b_count_q != BCNTBITS'(DIM)) begin
                                b_count_d = b_count_q + BCNTBITS'(1);
                            end else begin
                                b_count_d = b_count_q;
                            end
                        end
                        OP_CLEAR: begin
                            a_loaded_d = '0;
                            b_count_d  = '0;
                        end
                        OP_RUN: begin
                            if (operands_ready_s) begin
                                state_d = S_RUN;
                                cnt_d   = '0;
                                en_d    = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            // en_q is already high for the current count; drop it after the last one.
            S_RUN: begin
                if (cnt_q == CNTBITS'(RUN_CYCLES - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNTBITS'(1);
                    en_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                a_loaded_d = '0;
                b_count_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            a_loaded_q <= '0;
            b_count_q  <= '0;
            a_wren_q   <= 1'b0;
            a_row_q    <= '0;
            a_in_q     <= '0;
            b_wren_q   <= 1'b0;
            b_in_q     <= '0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_loaded_q <= a_loaded_d;
            b_count_q  <= b_count_d;
            a_wren_q   <= a_wren_d;
            a_row_q    <= a_row_d;
            a_in_q     <= a_in_d;
            b_wren_q   <= b_wren_d;
            b_in_q     <= b_in_d;
            en_q       <= en_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign a_wren = a_wren_q;
    assign a_row  = a_row_q;
    assign a_in   = a_in_q;
    assign b_wren = b_wren_q;
    assign b_in   = b_in_q;
    assign en     = en_q;
    assign busy   = en_q;
    assign done   = done_q;
    assign err    = err_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_q + {31'd0, en_q};
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: doc/tpu_seq.md
# tpu_seq

Command sequencer that sits directly upstream of memA/memB in the systolic-array datapath. It accepts row-load and run commands over a valid/ready handshake and turns them into memA row writes, memB shift-in writes and a timed `en` burst that streams both skewed matrices into the array. It raises a one-cycle done pulse at the end of each burst and tracks whether both operand matrices are fully loaded.

## Interface
- BITS_AB, 8, operand element width (signed)
- DIM, 8, array dimension; must be a power of 2, ≥2
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  opcode: LOAD_A=0, LOAD_B=1, RUN=2, CLEAR=3
- cmd_row  in  $clog2(DIM)  A row index (LOAD_A only)
- cmd_data  in  DIM×BITS_AB  signed row data (LOAD_A/LOAD_B)
- a_wren  out  1  memA WrEn
- a_row  out  $clog2(DIM)  memA Arow
- a_in  out  DIM×BITS_AB  memA Ain
- b_wren  out  1  memB WrEn
- b_in  out  DIM×BITS_AB  memB Bin
- en  out  1  shared memA/memB/array enable
- busy  out  1  RUN burst in progress
- done  out  1  one-cycle pulse after last `en` cycle
- err  out  1  one-cycle pulse on rejected RUN
- perf_cycles  out  32  busy-cycle counter (SEQ_PERF_CNT_EN only)

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- cmd_ready = 1 only in IDLE. Command accepted on cmd_valid && cmd_ready.
- LOAD_A: registers cmd_row/cmd_data onto a_row/a_in, a_wren high 1 cycle; sets a_loaded[cmd_row]. Rewriting a row is legal (overwrites).
- LOAD_B: registers cmd_data onto b_in, b_wren high 1 cycle; b_count increments, saturating at DIM.
- CLEAR: clears a_loaded and b_count; no memory strobes.
- RUN: if a_loaded is all-ones and b_count == DIM → RUN, else err pulse, remain IDLE, no `en`.
- RUN: `en` high for RUN_CYCLES = 3*DIM-2 consecutive cycles (2*DIM-1 skewed feed + DIM-1 propagation); busy high throughout. Cycle counter width $clog2(3*DIM-1).
- DONE: done high 1 cycle, a_loaded and b_count cleared (operands consumed), → IDLE.
- a_wren, b_wren and `en` are mutually exclusive in every cycle.
- a_in/b_in hold last written value between writes; no arithmetic performed on data.

## Timing
- Reset values: cmd_ready=0 during rst cycle, 1 the cycle after; a_wren=b_wren=en=busy=done=err=0; a_row=0; a_in=b_in=0; perf_cycles=0.
- Load latency: strobe in cycle N+1 for command accepted in cycle N. Back-to-back loads: one per cycle, no bubbles.
- RUN accepted in cycle N: en high cycles N+1..N+RUN_CYCLES; done in N+RUN_CYCLES+1; cmd_ready high again N+RUN_CYCLES+2.
- err asserted cycle N+1 for a rejected RUN accepted in N; cmd_ready stays high.
- Reset mid-RUN: en, busy low next cycle; counters and load flags cleared; no done pulse.
- cmd_valid while cmd_ready=0: ignored, command must be held by source.

## Configuration
- SEQ_PERF_CNT_EN defined: perf_cycles counts cycles with busy=1, wraps at 2^32, cleared only by rst.
- Not defined: perf_cycles port absent; no counter logic.

## Structure
- Shared package tpu_pkg: BITS_AB, DIM, ROWBITS, opcode enum (LOAD_A/LOAD_B/RUN/CLEAR), FSM state enum, RUN_CYCLES constant.
- Single module; no sub-module — counters and load tracking are inline.

## Test plan
- Reset then LOAD_A rows 0..7 with row i = {i,i,...} → a_wren 8 consecutive cycles, a_row 0..7, a_in matches one cycle after each accept.
- 8× LOAD_B then RUN with all A loaded → en high exactly 22 cycles (DIM=8), busy matches, done pulse on cycle 23, cmd_ready low throughout.
- RUN with only 7 A rows loaded → err pulse, en never high, cmd_ready stays 1.
- 10× LOAD_B, 8 A rows, RUN → accepted (b_count saturates); after done, immediate RUN → err (flags cleared).
- Assert rst at en cycle 10 of a burst → en/busy 0 next cycle, no done, subsequent RUN → err.
- With SEQ_PERF_CNT_EN: two complete RUNs → perf_cycles = 44; without macro, port absent and build passes.
